// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the ZBT SRAM controller slice.
//   - default address/data widths
//   - op pipeline depth (command edge to DQ edge)
//   - FSM state encodings
//   - op record layout {valid, is_write, data}
package sram_pkg;

  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_PIPE_DEPTH = 2;

  // state   | meaning
  // ST_INIT | waiting for the device clock/DLL to settle, not ready
  // ST_RUN  | accepting one request per cycle until reset
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Op record: {valid, is_write, data}. The control bits sit above the data,
  // so a record of any data width is DATA_WIDTH + OP_CTRL_W bits wide.
  localparam int OP_CTRL_W = 2;

  typedef struct packed {
    logic                       valid;
    logic                       is_write;
    logic [SRAM_DATA_WIDTH-1:0] data;
  } op_t;

endpackage

// File: rtl/sram_op_pipe.sv
// sram_op_pipe: fixed-depth shift register of op records, advancing every edge.
// Ports:
//   sram_clock  clock
//   reset       asynchronous active-low clear of every stage
//   op_in       record entering stage 0
//   op_out      record leaving the last stage
module sram_op_pipe
  import sram_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_WIDTH + OP_CTRL_W,
  parameter int DEPTH = SRAM_PIPE_DEPTH
) (
  input  logic             sram_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_in,
  output logic [WIDTH-1:0] op_out
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= op_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign op_out = stage[DEPTH-1];

endmodule

// File: rtl/sram_zbt_controller.sv
// sram_zbt_controller: arbiter-facing request/response port driving a
// pipelined ZBT SRAM. One request per cycle, fixed 3-edge read latency.
// Optional feature macro: SRAM_STATS_EN (adds stat_clear/stat_reads/stat_writes).
// Ports:
//   sram_clock, reset                 clock, async active-low reset
//   sram_addr_valid/sram_ready        request handshake
//   sram_addr/sram_data_in/
//   sram_write_mask                   request; mask 0 = read
//   sram_data_out/sram_data_out_valid read return, one-cycle pulse
//   sram_a/ce_n/we_n/bw_n/adv_ld_n/
//   oe_n                              device control pins
//   sram_dq_out/sram_dq_oe/sram_dq_in split DQ bus towards the IOBUFs
module sram_zbt_controller
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
  parameter int INIT_CYCLES = 256
) (
  input  logic                    sram_clock,
  input  logic                    reset,
  input  logic                    sram_addr_valid,
  output logic                    sram_ready,
  input  logic [ADDR_WIDTH-1:0]   sram_addr,
  input  logic [DATA_WIDTH-1:0]   sram_data_in,
  input  logic [DATA_WIDTH/8-1:0] sram_write_mask,
  output logic [DATA_WIDTH-1:0]   sram_data_out,
  output logic                    sram_data_out_valid,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_ce_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_bw_n,
  output logic                    sram_adv_ld_n,
  output logic                    sram_oe_n,
  output logic [DATA_WIDTH-1:0]   sram_dq_out,
  output logic                    sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]   sram_dq_in
`ifdef SRAM_STATS_EN
  ,
  input  logic                    stat_clear,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes
`endif
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(INIT_CYCLES + 1);
  localparam int OP_W   = DATA_WIDTH + OP_CTRL_W;

  logic [0:0]       state;
  logic [CNT_W-1:0] init_cnt;
  logic             accept;
  logic             is_write;
  logic [OP_W-1:0]  op_in;
  logic [OP_W-1:0]  op_out;
  logic             op_valid;
  logic             op_is_write;

  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (init_cnt == CNT_W'(INIT_CYCLES - 1)) state <= ST_RUN;
      else                                     init_cnt <= init_cnt + 1'b1;
    end
  end

  assign sram_ready = (state == ST_RUN);
  assign accept     = sram_addr_valid & sram_ready;
  assign is_write   = |sram_write_mask;

  // Command pins: sram_a keeps its last value on idle cycles.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      sram_a    <= '0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_bw_n <= '1;
    end else if (accept) begin
      sram_a    <= sram_addr;
      sram_ce_n <= 1'b0;
      sram_we_n <= ~is_write;
      sram_bw_n <= is_write ? ~sram_write_mask : {MASK_W{1'b1}};
    end else begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_bw_n <= '1;
    end
  end

  // Address is loaded every cycle; burst mode is never used.
  assign sram_adv_ld_n = 1'b0;

  assign op_in = {accept, is_write, sram_data_in};

  sram_op_pipe #(
    .WIDTH (OP_W),
    .DEPTH (SRAM_PIPE_DEPTH)
  ) u_op_pipe (
    .sram_clock (sram_clock),
    .reset      (reset),
    .op_in      (op_in),
    .op_out     (op_out)
  );

  assign op_valid    = op_out[OP_W-1];
  assign op_is_write = op_out[OP_W-2];

  // Data phase: the write and read enables come from the same record, so
  // sram_dq_oe and an active sram_oe_n are mutually exclusive by construction.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
      sram_oe_n   <= 1'b1;
    end else begin
      sram_dq_oe <= op_valid & op_is_write;
      sram_oe_n  <= ~(op_valid & ~op_is_write);
      if (op_valid & op_is_write) sram_dq_out <= op_out[DATA_WIDTH-1:0];
    end
  end

  // Read return: sample DQ at the edge closing the output-enable window.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      sram_data_out       <= '0;
      sram_data_out_valid <= 1'b0;
    end else begin
      sram_data_out_valid <= ~sram_oe_n;
      if (!sram_oe_n) sram_data_out <= sram_dq_in;
    end
  end

`ifdef SRAM_STATS_EN
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (stat_clear) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (accept) begin
      if (is_write) stat_writes <= stat_writes + 32'd1;
      else          stat_reads  <= stat_reads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_zbt_controller.sv
// tb_sram_zbt_controller: directed bench for sram_zbt_controller with a
// negedge ZBT device model and an in-order read scoreboard.
module tb_sram_zbt_controller;

  localparam int AW   = 18;
  localparam int DW   = 32;
  localparam int INIT = 16;

  logic          sram_clock = 1'b0;
  logic          reset = 1'b0;
  logic          sram_addr_valid = 1'b0;
  logic          sram_ready;
  logic [AW-1:0] sram_addr = '0;
  logic [DW-1:0] sram_data_in = '0;
  logic [3:0]    sram_write_mask = '0;
  logic [DW-1:0] sram_data_out;
  logic          sram_data_out_valid;
  logic [AW-1:0] sram_a;
  logic          sram_ce_n, sram_we_n, sram_adv_ld_n, sram_oe_n, sram_dq_oe;
  logic [3:0]    sram_bw_n;
  logic [DW-1:0] sram_dq_out;
  logic [DW-1:0] sram_dq_in = '0;
`ifdef SRAM_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_reads, stat_writes;
`endif

  sram_zbt_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_CYCLES(INIT)) dut (
    .sram_clock          (sram_clock),
    .reset               (reset),
    .sram_addr_valid     (sram_addr_valid),
    .sram_ready          (sram_ready),
    .sram_addr           (sram_addr),
    .sram_data_in        (sram_data_in),
    .sram_write_mask     (sram_write_mask),
    .sram_data_out       (sram_data_out),
    .sram_data_out_valid (sram_data_out_valid),
    .sram_a              (sram_a),
    .sram_ce_n           (sram_ce_n),
    .sram_we_n           (sram_we_n),
    .sram_bw_n           (sram_bw_n),
    .sram_adv_ld_n       (sram_adv_ld_n),
    .sram_oe_n           (sram_oe_n),
    .sram_dq_out         (sram_dq_out),
    .sram_dq_oe          (sram_dq_oe),
    .sram_dq_in          (sram_dq_in)
`ifdef SRAM_STATS_EN
    ,
    .stat_clear          (stat_clear),
    .stat_reads          (stat_reads),
    .stat_writes         (stat_writes)
`endif
  );

  always #5 sram_clock = ~sram_clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int since_rst = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Device model: command sampled mid-cycle, data phase two negedges later.
  logic [31:0] dmem [logic [17:0]];
  logic        c1_v = 0, c1_w = 0, c2_v = 0, c2_w = 0;
  logic [3:0]  c1_bw = '1, c2_bw = '1;
  logic [17:0] c1_a = '0, c2_a = '0;

  always @(negedge sram_clock) begin
    logic [31:0] cur;
    if (c2_v) begin
      cur = dmem.exists(c2_a) ? dmem[c2_a] : 32'h0;
      if (c2_w) begin
        if (sram_dq_oe)
          for (int b = 0; b < 4; b++)
            if (!c2_bw[b]) cur[b*8 +: 8] = sram_dq_out[b*8 +: 8];
        dmem[c2_a] = cur;
      end else begin
        sram_dq_in = cur;
      end
    end
    c2_v = c1_v; c2_w = c1_w; c2_bw = c1_bw; c2_a = c1_a;
    c1_v = ~sram_ce_n; c1_w = ~sram_we_n; c1_bw = sram_bw_n; c1_a = sram_a;
  end

  // Reference memory and expected-read queue, updated at issue time.
  typedef struct { logic [31:0] data; int due; } rd_t;
  rd_t         rq[$];
  logic [31:0] rmem [logic [17:0]];

  always @(negedge sram_clock) begin
    logic exp_v;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_v || sram_data_out_valid) begin
      check("rd_valid", sram_data_out_valid, exp_v);
      if (exp_v) begin
        check("rd_data", sram_data_out, rq[0].data);
        void'(rq.pop_front());
      end
    end
    if (sram_data_out_valid) pulses++;
    if (reset) check("dq_oe_oe_n_overlap", sram_dq_oe & ~sram_oe_n, 0);
  end

  task automatic drive(input logic v, input logic [17:0] a, input logic [31:0] d, input logic [3:0] m);
    sram_addr_valid = v; sram_addr = a; sram_data_in = d; sram_write_mask = m;
  endtask

  // One clock edge; returns at the following negedge.
  task automatic step();
    logic [31:0] cur;
    rd_t e;
    @(posedge sram_clock);
    cyc++;
    if (reset && sram_addr_valid && since_rst >= INIT) begin
      cur = rmem.exists(sram_addr) ? rmem[sram_addr] : 32'h0;
      if (sram_write_mask == 4'h0) begin
        e.data = cur; e.due = cyc + 3; rq.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_write_mask[b]) cur[b*8 +: 8] = sram_data_in[b*8 +: 8];
        rmem[sram_addr] = cur;
      end
    end
    since_rst++;
    @(negedge sram_clock);
  endtask

  initial begin
    repeat (3) @(negedge sram_clock);
    check("rst_ready", sram_ready, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_bw_n", sram_bw_n, 4'hF);
    check("rst_adv_ld_n", sram_adv_ld_n, 0);
    reset = 1'b1; since_rst = 0;

    // 1: init window with valid held high
    drive(1, 18'h0, 32'h0, 4'h0);
    for (int k = 1; k <= INIT; k++) begin
      step();
      check("init_ready", sram_ready, (k >= INIT) ? 1 : 0);
      check("init_ce_n", sram_ce_n, 1);
    end
    step();
    check("first_accept_ce_n", sram_ce_n, 0);

    // 2: full write
    drive(1, 18'h00010, 32'hDEADBEEF, 4'hF);
    step();
    check("w_a", sram_a, 18'h00010);
    check("w_we_n", sram_we_n, 0);
    check("w_bw_n", sram_bw_n, 4'h0);
    drive(0, 18'h0, 32'h0, 4'h0);
    step();
    check("w_ce_n_idle", sram_ce_n, 1);
    check("w_a_hold", sram_a, 18'h00010);
    check("w_dq_oe_early", sram_dq_oe, 0);
    step();
    check("w_dq_oe", sram_dq_oe, 1);
    check("w_dq_out", sram_dq_out, 32'hDEADBEEF);
    check("w_oe_n", sram_oe_n, 1);
    step();
    check("w_dq_oe_release", sram_dq_oe, 0);

    // 3: partial write merged, then read back
    drive(1, 18'h00020, 32'h11223344, 4'hF);
    step();
    drive(1, 18'h00020, 32'hAABBCCDD, 4'b0101);
    step();
    check("pw_bw_n", sram_bw_n, 4'b1010);
    drive(1, 18'h00020, 32'h0, 4'h0);
    step();
    check("r_we_n", sram_we_n, 1);
    check("r_bw_n", sram_bw_n, 4'hF);
    drive(0, 18'h0, 32'h0, 4'h0);
    step();
    check("r_valid_e1", sram_data_out_valid, 0);
    step();
    check("r_oe_n", sram_oe_n, 0);
    check("r_valid_e2", sram_data_out_valid, 0);
    step();
    check("r_valid_e3", sram_data_out_valid, 1);
    check("r_merged", sram_data_out, 32'h11BB33DD);
    step();
    check("r_valid_e4", sram_data_out_valid, 0);
    check("r_hold", sram_data_out, 32'h11BB33DD);

    // 4: alternating write/read-back stream
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) drive(1, 18'h200 + 18'(i), (32'h200 + i) ^ 32'hA5A5A5A5, 4'hF);
      else            drive(1, 18'h200 + 18'(i - 1), 32'h0, 4'h0);
      step();
      check("stream_ready", sram_ready, 1);
    end
    drive(0, 18'h0, 32'h0, 4'h0);
    repeat (4) step();
    check("stream_pulses", pulses, 32);
    check("stream_last", sram_data_out, 32'h23E ^ 32'hA5A5A5A5);

    // 5: reset while a read is in flight
    drive(1, 18'h00202, 32'h0, 4'h0);
    step();
    drive(0, 18'h0, 32'h0, 4'h0);
    step();
    #2 reset = 1'b0;
    rq.delete();
    #1;
    check("mr_ready", sram_ready, 0);
    check("mr_data_out", sram_data_out, 0);
    check("mr_valid", sram_data_out_valid, 0);
    check("mr_a", sram_a, 0);
    check("mr_ce_n", sram_ce_n, 1);
    check("mr_we_n", sram_we_n, 1);
    check("mr_bw_n", sram_bw_n, 4'hF);
    check("mr_oe_n", sram_oe_n, 1);
    check("mr_dq_oe", sram_dq_oe, 0);
    check("mr_dq_out", sram_dq_out, 0);
    repeat (3) step();
    reset = 1'b1; since_rst = 0;
    drive(1, 18'h00202, 32'h0, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("reinit_ready", sram_ready, 0);
      check("reinit_ce_n", sram_ce_n, 1);
    end
    drive(0, 18'h0, 32'h0, 4'h0);
    repeat (INIT - 3) step();
    check("reinit_done", sram_ready, 1);

`ifdef SRAM_STATS_EN
    // 6: statistics counters
    check("stat_rst_w", stat_writes, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 18'h300 + 18'(i), 32'h1000 + i, 4'hF);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 18'h300 + 18'(i), 32'h0, 4'h0);
      step();
    end
    drive(0, 18'h0, 32'h0, 4'h0);
    repeat (4) step();
    check("stat_writes", stat_writes, 5);
    check("stat_reads", stat_reads, 3);
    stat_clear = 1'b1;
    drive(1, 18'h301, 32'h0, 4'h0);
    step();
    stat_clear = 1'b0;
    drive(0, 18'h0, 32'h0, 4'h0);
    check("stat_clr_w", stat_writes, 0);
    check("stat_clr_r", stat_reads, 0);
    step();
    check("stat_clr_r_hold", stat_reads, 0);
`endif

    repeat (5) step();
    check("queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
